matrix_chain_driver: RTL

Parametrised driver for a daisy chain of MAX7219 8x8 LED matrix devices arranged as a TILES_X x TILES_Y mosaic. It accepts a full-frame bitmap through a valid/ready handshake and runs the device init sequence. It serialises the frame onto DIN/CS/LED_CLK at a divided serial clock. Frame-to-frame brightness is runtime-adjustable. It sits between the game-logic frame generator and the board's matrix header, and serves as the generalised successor of the fixed 16x16 display driver.

---
 rtl/matrix_pkg.sv | 49 ++++
 rtl/max7219_shifter.sv | 100 ++++++++++
 rtl/matrix_chain_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the MAX7219 matrix chain driver: register map,
// command word layout, sequencer states and the init command table.
package matrix_pkg;

  // MAX7219 register addresses
  localparam logic [7:0] REG_DIGIT1    = 8'h01;
  localparam logic [7:0] REG_DIGIT2    = 8'h02;
  localparam logic [7:0] REG_DIGIT3    = 8'h03;
  localparam logic [7:0] REG_DIGIT4    = 8'h04;
  localparam logic [7:0] REG_DIGIT5    = 8'h05;
  localparam logic [7:0] REG_DIGIT6    = 8'h06;
  localparam logic [7:0] REG_DIGIT7    = 8'h07;
  localparam logic [7:0] REG_DIGIT8    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int unsigned INIT_CMDS = 5;
  localparam int unsigned ROW_CMDS  = 8;

  // One 16-bit device word, shifted MSB first
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_INTENS,
    ST_ROWS
  } state_t;

  // Power-up command table; intensity comes from the live brightness register
  function automatic cmd_t init_cmd(input logic [2:0] idx, input logic [3:0] bri);
    cmd_t c;
    case (idx)
      3'd0:    c = {REG_TEST, 8'h00};
      3'd1:    c = {REG_SCANLIMIT, 8'h07};
      3'd2:    c = {REG_DECODE, 8'h00};
      3'd3:    c = {REG_INTENSITY, 4'h0, bri};
      default: c = {REG_SHUTDOWN, 8'h01};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/max7219_shifter.sv
// Serialises one command (N_DEV words, highest device first, MSB first) onto
// the MAX7219 chain, followed by a CLK_DIV-cycle latch interval with CS high.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   start           launch request; taken when idle or in the last latch cycle
//   words           command words, words[N_DEV-1] leaves first
//   done            high during the last latch cycle of a command
//   DIN, CS, LED_CLK  registered serial interface
module max7219_shifter
  import matrix_pkg::*;
#(
  parameter int unsigned N_DEV   = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  cmd_t [N_DEV-1:0]      words,
  output logic                  done,
  output logic                  DIN,
  output logic                  CS,
  output logic                  LED_CLK
);

  localparam int unsigned NBITS = 16 * N_DEV;
  localparam int unsigned PH_W  = $clog2(CLK_DIV);
  localparam int unsigned BC_W  = $clog2(NBITS);

  localparam logic [PH_W-1:0] PH_HALF    = PH_W'(CLK_DIV / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_PRELAST = PH_W'(CLK_DIV - 2);
  localparam logic [BC_W-1:0] BC_LAST    = BC_W'(NBITS - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("max7219_shifter: CLK_DIV must be even and >= 2");
  end

  logic              active;
  logic              latching;
  logic [PH_W-1:0]   phase;
  logic [BC_W-1:0]   bit_cnt;
  logic [NBITS-2:0]  sr;          // bits still to send after the one on DIN
  logic [NBITS-1:0]  words_flat;
  logic              load_c;

  assign words_flat = words;
  // Back-to-back commands reload in the final latch cycle
  assign load_c = start && (!active || (latching && phase == PH_LAST));

  // Bit timing: DIN changes with LED_CLK low, LED_CLK high for the second half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      latching <= 1'b0;
      phase    <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      done     <= 1'b0;
      DIN      <= 1'b0;
      CS       <= 1'b1;
      LED_CLK  <= 1'b0;
    end else if (load_c) begin
      active   <= 1'b1;
      latching <= 1'b0;
      phase    <= '0;
      bit_cnt  <= '0;
      sr       <= words_flat[NBITS-2:0];
      done     <= 1'b0;
      DIN      <= words_flat[NBITS-1];
      CS       <= 1'b0;
      LED_CLK  <= 1'b0;
    end else if (active) begin
      phase <= phase + 1'b1;
      if (latching) begin
        done <= (phase == PH_PRELAST);
        if (phase == PH_LAST) begin
          active   <= 1'b0;
          latching <= 1'b0;
          phase    <= '0;
          done     <= 1'b0;
        end
      end else if (phase == PH_LAST) begin
        phase   <= '0;
        LED_CLK <= 1'b0;
        if (bit_cnt == BC_LAST) begin
          latching <= 1'b1;
          CS       <= 1'b1;
          DIN      <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          DIN     <= sr[NBITS-2];
          sr      <= {sr[NBITS-3:0], 1'b0};
        end
      end else if (phase == PH_HALF) begin
        LED_CLK <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_chain_driver.sv
// Frame driver for a TILES_X x TILES_Y mosaic of MAX7219 8x8 matrices.
// Runs the init sequence after reset, then per accepted frame sends an
// optional intensity update followed by the eight digit rows.
// Optional feature: define MATRIX_REINIT_EN to rerun the full init sequence
// after every REINIT_FRAMES accepted frames.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   grid            frame bitmap, grid[r][c], r=0 top, c=0 left
//   frame_valid     grid/brightness valid
//   frame_ready     idle, frame accepted this cycle if frame_valid
//   brightness      intensity value sampled at handshake
//   busy            high whenever not idle
//   DIN, CS, LED_CLK  serial chain interface
module matrix_chain_driver
  import matrix_pkg::*;
#(
  parameter int unsigned TILES_X       = 2,
  parameter int unsigned TILES_Y       = 2,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned REINIT_FRAMES = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [8*TILES_Y-1:0][8*TILES_X-1:0]    grid,
  input  logic                                   frame_valid,
  output logic                                   frame_ready,
  input  logic [3:0]                             brightness,
  output logic                                   busy,
  output logic                                   DIN,
  output logic                                   CS,
  output logic                                   LED_CLK
);

  localparam int unsigned N_DEV = TILES_X * TILES_Y;
  localparam int unsigned W     = 8 * TILES_X;
  localparam int unsigned H     = 8 * TILES_Y;
  localparam int unsigned RW    = $clog2(H);

  if (REINIT_FRAMES < 1) begin : g_bad_reinit
    $error("matrix_chain_driver: REINIT_FRAMES must be >= 1");
  end

  state_t                 state;
  logic [2:0]             cmd_idx;
  logic                   kick;          // first command of a sequence pending
  logic [3:0]             brightness_reg;
  logic [H-1:0][W-1:0]    shadow;

  state_t                 load_state;
  logic [2:0]             load_idx;
  logic                   start_c;
  logic                   done;
  logic                   handshake_c;
  logic                   reinit_c;
  cmd_t                   bcast_c;
  cmd_t [N_DEV-1:0]       words_c;

  assign handshake_c = (state == ST_IDLE) && frame_valid && frame_ready;

`ifdef MATRIX_REINIT_EN
  localparam int unsigned FC_W = $clog2(REINIT_FRAMES + 1);
  logic [FC_W-1:0] frame_cnt;

  // Accepted-frame counter; cleared when the forced init is launched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (start_c && state == ST_ROWS && load_state == ST_INIT) begin
      frame_cnt <= '0;
    end else if (handshake_c) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign reinit_c = (frame_cnt == FC_W'(REINIT_FRAMES));
`else
  assign reinit_c = 1'b0;
`endif

  // Which command the shifter takes this cycle (kick, or chaining on done)
  always_comb begin
    start_c    = 1'b0;
    load_state = state;
    load_idx   = cmd_idx;
    if (kick) begin
      start_c = 1'b1;
    end else if (done) begin
      case (state)
        ST_INIT: begin
          if (cmd_idx != 3'(INIT_CMDS - 1)) begin
            start_c  = 1'b1;
            load_idx = cmd_idx + 3'd1;
          end
        end
        ST_INTENS: begin
          start_c    = 1'b1;
          load_state = ST_ROWS;
          load_idx   = 3'd0;
        end
        ST_ROWS: begin
          if (cmd_idx != 3'(ROW_CMDS - 1)) begin
            start_c  = 1'b1;
            load_idx = cmd_idx + 3'd1;
          end else if (reinit_c) begin
            start_c    = 1'b1;
            load_state = ST_INIT;
            load_idx   = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Same word to every device for init and intensity commands
  always_comb begin
    bcast_c = init_cmd(load_idx, brightness_reg);
    if (load_state == ST_INTENS) begin
      bcast_c = {REG_INTENSITY, 4'h0, brightness_reg};
    end
  end

  // Row words: device d shows rows 8*ty.. and columns 8*tx.., left column in bit 7
  for (genvar d = 0; d < N_DEV; d++) begin : g_dev
    localparam int unsigned TY = d / TILES_X;
    localparam int unsigned TX = d % TILES_X;
    logic [RW-1:0] row_sel;
    logic [7:0]    digit;

    assign row_sel = RW'(8 * TY) + RW'(load_idx);
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign digit[7-j] = shadow[row_sel][8*TX+j];
    end
    assign words_c[d] = (load_state == ST_ROWS) ? {REG_DIGIT1 + 8'(load_idx), digit} : bcast_c;
  end

  // Sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_INIT;
      cmd_idx        <= 3'd0;
      kick           <= 1'b1;
      frame_ready    <= 1'b0;
      busy           <= 1'b1;
      brightness_reg <= 4'hF;
      shadow         <= '0;
    end else begin
      if (start_c) begin
        state   <= load_state;
        cmd_idx <= load_idx;
        kick    <= 1'b0;
      end else if (done) begin
        state       <= ST_IDLE;
        cmd_idx     <= 3'd0;
        frame_ready <= 1'b1;
        busy        <= 1'b0;
      end else if (handshake_c) begin
        shadow      <= grid;
        frame_ready <= 1'b0;
        busy        <= 1'b1;
        kick        <= 1'b1;
        cmd_idx     <= 3'd0;
        if (brightness != brightness_reg) begin
          state          <= ST_INTENS;
          brightness_reg <= brightness;
        end else begin
          state <= ST_ROWS;
        end
      end
    end
  end

  max7219_shifter #(
    .N_DEV   (N_DEV),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (start_c),
    .words   (words_c),
    .done    (done),
    .DIN     (DIN),
    .CS      (CS),
    .LED_CLK (LED_CLK)
  );

endmodule
